// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsuState_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication and load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLow,
    input  logic [31:0] storeData,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] loadValue
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata >> {addrLow, 3'b000};
        be        = 4'b1111;
        wdata     = storeData;
        loadValue = shifted;
        case (funct3)
            F3_B: begin
                be        = 4'b0001 << addrLow;
                wdata     = {4{storeData[7:0]}};
                loadValue = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                be        = 4'b0001 << addrLow;
                wdata     = {4{storeData[7:0]}};
                loadValue = {24'd0, shifted[7:0]};
            end
            F3_H: begin
                be        = 4'b0011 << addrLow;
                wdata     = {2{storeData[15:0]}};
                loadValue = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_HU: begin
                be        = 4'b0011 << addrLow;
                wdata     = {2{storeData[15:0]}};
                loadValue = {16'd0, shifted[15:0]};
            end
            default: begin
                be        = 4'b1111;
                wdata     = storeData;
                loadValue = shifted;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: issues data-memory requests and stalls until the bus answers.
module mem_stage_lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_req_addr,
    output logic        dmem_req_we,
    output logic [3:0]  dmem_req_be,
    output logic [31:0] dmem_req_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output logic [31:0] wb_alu_output,
    output logic [31:0] wb_data_output,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic        wb_en,
    output logic        stall,
    output logic        misaligned
);

    lsuState_e   state, nextState;
    logic [31:0] addrQ, storeDataQ, loadDataQ;
    logic        weQ;
    logic [2:0]  funct3Q;
    logic [1:0]  addrLowQ;
    logic [31:0] loadValue;
    logic        memOp, badAccess, illegal;

    // Raw store data is captured and aligned from the captured funct3/offset,
    // so the bus lanes stay stable for the whole request.
    lsu_align u_align (
        .funct3    (funct3Q),
        .addrLow   (addrLowQ),
        .storeData (storeDataQ),
        .rdata     (dmem_rsp_rdata),
        .be        (dmem_req_be),
        .wdata     (dmem_req_wdata),
        .loadValue (loadValue)
    );

    always_comb begin
        memOp = ex_valid & (ex_mem_read | ex_mem_write);
        case (ex_funct3)
            F3_B:    badAccess = 1'b0;
            F3_BU:   badAccess = ex_mem_write;
            F3_H:    badAccess = ex_alu_result[0];
            F3_HU:   badAccess = ex_alu_result[0] | ex_mem_write;
            F3_W:    badAccess = |ex_alu_result[1:0];
            default: badAccess = 1'b1;
        endcase
        illegal = memOp & (badAccess | (ex_mem_read & ex_mem_write));
    end

    always_comb begin
        nextState      = state;
        dmem_req_valid = 1'b0;
        stall          = 1'b0;
        wb_en          = 1'b0;
        misaligned     = 1'b0;
        wb_reg_write   = ex_valid & ex_reg_write;
        case (state)
            IDLE: begin
                if (illegal) begin
                    misaligned   = 1'b1;
                    wb_reg_write = 1'b0;
                    wb_en        = 1'b1;
                end else if (memOp) begin
                    stall     = 1'b1;
                    nextState = REQ;
                end else begin
                    wb_en = 1'b1;
                end
            end
            REQ: begin
                dmem_req_valid = 1'b1;
                stall          = 1'b1;
                if (dmem_req_ready) nextState = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_rsp_valid) nextState = DONE;
            end
            DONE: begin
                wb_en     = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (!rst) begin
            dmem_req_valid = 1'b0;
            stall          = 1'b0;
            wb_en          = 1'b0;
            misaligned     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            addrQ      <= '0;
            storeDataQ <= '0;
            weQ        <= 1'b0;
            funct3Q    <= '0;
            addrLowQ   <= '0;
            loadDataQ  <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && memOp && !illegal) begin
                addrQ      <= {ex_alu_result[31:2], 2'b00};
                storeDataQ <= ex_store_data;
                weQ        <= ex_mem_write;
                funct3Q    <= ex_funct3;
                addrLowQ   <= ex_alu_result[1:0];
            end
            if (state == WAIT && dmem_rsp_valid && !weQ) loadDataQ <= loadValue;
        end
    end

    assign dmem_req_addr  = addrQ;
    assign dmem_req_we    = weQ;
    assign wb_alu_output  = ex_alu_result;
    assign wb_data_output = loadDataQ;
    assign wb_rd          = ex_rd;
    assign wb_mem_to_reg  = ex_mem_to_reg;

endmodule
